control_unit: RTL and testbench

- Multicycle control FSM that sits directly upstream of the cpu1 datapath and drives every datapath write enable, mux select and ALU selector.
- Consumes the IR opcode/funct fields and the ula32 flags (Overflow, Igual).
- Sequences fetch, decode, execute, memory and writeback for the base MIPS subset: add, sub, and, addi, lw, sw, beq, bne, j.
- Halts in an exception state on overflow or an illegal instruction.

---
 rtl/control_pkg.sv | 99 +++++++++
 rtl/control_unit.sv | 262 ++++++++++++++++++++++++++
 tb/tb_control_unit.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_pkg.sv
// ---------------------------------------------------------------------------
// control_pkg
// Shared definitions for the multicycle MIPS control unit:
//   - state_e       : FSM state encoding (also exported on state_out)
//   - OP_* / FN_*   : IR opcode and R-type funct field values
//   - MUXn_*        : datapath mux select codes
//   - ULA_*         : ula32 operation codes
//   - EXC_*         : exception cause codes
// Helper functions decode the supported R-type funct values.
// ---------------------------------------------------------------------------
package control_pkg;

    typedef enum logic [4:0] {
        ST_RESET  = 5'd0,
        ST_FETCH  = 5'd1,
        ST_DECODE = 5'd2,
        ST_EXEC_R = 5'd3,
        ST_WB_R   = 5'd4,
        ST_EXEC_I = 5'd5,
        ST_WB_I   = 5'd6,
        ST_ADDR   = 5'd7,
        ST_MEM_RD = 5'd8,
        ST_WB_LW  = 5'd9,
        ST_MEM_WR = 5'd10,
        ST_BR     = 5'd11,
        ST_JUMP   = 5'd12,
        ST_EXC    = 5'd13
    } state_e;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct values (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;

    // Memory address select
    localparam logic [2:0] MUX1_PC     = 3'd0;
    localparam logic [2:0] MUX1_ALUOUT = 3'd1;
    // Write-register select
    localparam logic [2:0] MUX2_RT     = 3'd0;
    localparam logic [2:0] MUX2_RD     = 3'd1;
    // Write-data select
    localparam logic [2:0] MUX3_MDR    = 3'd0;
    localparam logic [2:0] MUX3_ALUOUT = 3'd1;
    // ALU A select
    localparam logic [2:0] MUX4_PC     = 3'd0;
    localparam logic [2:0] MUX4_A      = 3'd1;
    // ALU B select
    localparam logic [2:0] MUX5_B      = 3'd0;
    localparam logic [2:0] MUX5_IMM    = 3'd1;
    localparam logic [2:0] MUX5_IMM_SH = 3'd2;
    localparam logic [2:0] MUX5_FOUR   = 3'd3;
    // PC source select
    localparam logic [2:0] MUX13_ALU    = 3'd0;
    localparam logic [2:0] MUX13_ALUOUT = 3'd1;
    localparam logic [2:0] MUX13_JUMP   = 3'd2;

    // ula32 operations
    localparam logic [2:0] ULA_NONE = 3'b000;
    localparam logic [2:0] ULA_ADD  = 3'b001;
    localparam logic [2:0] ULA_SUB  = 3'b010;
    localparam logic [2:0] ULA_AND  = 3'b011;

    // Exception causes
    localparam logic [1:0] EXC_NONE    = 2'b00;
    localparam logic [1:0] EXC_ILLEGAL = 2'b01;
    localparam logic [1:0] EXC_OVF     = 2'b10;

    // True for the R-type funct values this control unit can execute.
    function automatic logic funct_is_legal(input logic [5:0] fn);
        return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND);
    endfunction

    // True for the R-type operations whose overflow is trapped.
    function automatic logic funct_traps_ovf(input logic [5:0] fn);
        return (fn == FN_ADD) || (fn == FN_SUB);
    endfunction

    // ula32 operation for a legal R-type funct.
    function automatic logic [2:0] funct_to_ula(input logic [5:0] fn);
        logic [2:0] op;
        case (fn)
            FN_ADD:  op = ULA_ADD;
            FN_SUB:  op = ULA_SUB;
            FN_AND:  op = ULA_AND;
            default: op = ULA_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
// Multicycle control FSM for the cpu1 datapath (add, sub, and, addi, lw, sw,
// beq, bne, j). Produces every datapath write enable, mux select and the ALU
// operation; halts in an exception state on overflow or illegal instruction.
//
// Parameters:
//   MEM_LAT       wait cycles from address presentation to data capture (1..7)
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-low reset
//   opcode,funct  IR[31:26] and IR[5:0]
//   Overflow,Igual ula32 flags
//   PC_w, memoria_w, IR_w, MDR_w, reg_w, a_w, b_w, ALUOut_w   write enables
//   mux1_s..mux13_s  datapath mux selects
//   ula_selector  ula32 operation
//   exc, exc_cause exception halt flag and cause
//   state_out     current state encoding (debug)
// ---------------------------------------------------------------------------
module control_unit
    import control_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       Overflow,
    input  logic       Igual,
    output logic       PC_w,
    output logic       memoria_w,
    output logic       IR_w,
    output logic       MDR_w,
    output logic       reg_w,
    output logic       a_w,
    output logic       b_w,
    output logic       ALUOut_w,
    output logic [2:0] mux1_s,
    output logic [2:0] mux2_s,
    output logic [2:0] mux3_s,
    output logic [2:0] mux4_s,
    output logic [2:0] mux5_s,
    output logic [2:0] mux13_s,
    output logic [2:0] ula_selector,
    output logic       exc,
    output logic [1:0] exc_cause,
    output logic [4:0] state_out
);

    localparam logic [2:0] LAT = MEM_LAT[2:0];

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [1:0] exc_cause_q, exc_cause_d;
    logic       mem_done;

    // Memory access completes on the cycle the wait counter reaches MEM_LAT,
    // so FETCH and MEM_RD each last MEM_LAT+1 cycles.
    assign mem_done = (cnt_q == LAT);

    // -----------------------------------------------------------------------
    // Next-state, wait counter and exception cause
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = 3'd0;     // counter is only live in FETCH / MEM_RD
        exc_cause_d = exc_cause_q;

        case (state_q)
            ST_RESET: state_d = ST_FETCH;

            ST_FETCH: begin
                if (mem_done) begin
                    state_d = ST_DECODE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE: begin
                        if (funct_is_legal(funct)) begin
                            state_d = ST_EXEC_R;
                        end else begin
                            state_d     = ST_EXC;
                            exc_cause_d = EXC_ILLEGAL;
                        end
                    end
                    OP_ADDI:       state_d = ST_EXEC_I;
                    OP_LW, OP_SW:  state_d = ST_ADDR;
                    OP_BEQ, OP_BNE: state_d = ST_BR;
                    OP_J:          state_d = ST_JUMP;
                    default: begin
                        state_d     = ST_EXC;
                        exc_cause_d = EXC_ILLEGAL;
                    end
                endcase
            end

            ST_EXEC_R: begin
                // 'and' cannot overflow, so its flag is ignored.
                if (Overflow && funct_traps_ovf(funct)) begin
                    state_d     = ST_EXC;
                    exc_cause_d = EXC_OVF;
                end else begin
                    state_d = ST_WB_R;
                end
            end

            ST_EXEC_I: begin
                if (Overflow) begin
                    state_d     = ST_EXC;
                    exc_cause_d = EXC_OVF;
                end else begin
                    state_d = ST_WB_I;
                end
            end

            // Address arithmetic never traps on overflow.
            ST_ADDR: state_d = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;

            ST_MEM_RD: begin
                if (mem_done) begin
                    state_d = ST_WB_LW;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            ST_WB_R, ST_WB_I, ST_WB_LW, ST_MEM_WR, ST_BR, ST_JUMP:
                state_d = ST_FETCH;

            ST_EXC: state_d = ST_EXC;   // terminal until reset

            default: state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RESET;
            cnt_q       <= 3'd0;
            exc_cause_q <= EXC_NONE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            exc_cause_q <= exc_cause_d;
        end
    end

    // -----------------------------------------------------------------------
    // Output decode (Moore, except PC_w in BR which follows Igual)
    // -----------------------------------------------------------------------
    always_comb begin
        PC_w         = 1'b0;
        memoria_w    = 1'b0;
        IR_w         = 1'b0;
        MDR_w        = 1'b0;
        reg_w        = 1'b0;
        a_w          = 1'b0;
        b_w          = 1'b0;
        ALUOut_w     = 1'b0;
        mux1_s       = MUX1_PC;
        mux2_s       = MUX2_RT;
        mux3_s       = MUX3_MDR;
        mux4_s       = MUX4_PC;
        mux5_s       = MUX5_B;
        mux13_s      = MUX13_ALU;
        ula_selector = ULA_NONE;

        case (state_q)
            ST_FETCH: begin
                mux1_s = MUX1_PC;
                if (mem_done) begin
                    // Latch the instruction and advance PC <= PC + 4.
                    IR_w         = 1'b1;
                    PC_w         = 1'b1;
                    mux4_s       = MUX4_PC;
                    mux5_s       = MUX5_FOUR;
                    ula_selector = ULA_ADD;
                    mux13_s      = MUX13_ALU;
                end
            end

            ST_DECODE: begin
                // Read operands and precompute the branch target.
                a_w          = 1'b1;
                b_w          = 1'b1;
                mux4_s       = MUX4_PC;
                mux5_s       = MUX5_IMM_SH;
                ula_selector = ULA_ADD;
                ALUOut_w     = 1'b1;
            end

            ST_EXEC_R: begin
                mux4_s       = MUX4_A;
                mux5_s       = MUX5_B;
                ula_selector = funct_to_ula(funct);
                ALUOut_w     = 1'b1;
            end

            ST_WB_R: begin
                reg_w  = 1'b1;
                mux2_s = MUX2_RD;
                mux3_s = MUX3_ALUOUT;
            end

            ST_EXEC_I, ST_ADDR: begin
                mux4_s       = MUX4_A;
                mux5_s       = MUX5_IMM;
                ula_selector = ULA_ADD;
                ALUOut_w     = 1'b1;
            end

            ST_WB_I: begin
                reg_w  = 1'b1;
                mux2_s = MUX2_RT;
                mux3_s = MUX3_ALUOUT;
            end

            ST_MEM_RD: begin
                mux1_s = MUX1_ALUOUT;
                MDR_w  = mem_done;
            end

            ST_WB_LW: begin
                reg_w  = 1'b1;
                mux2_s = MUX2_RT;
                mux3_s = MUX3_MDR;
            end

            ST_MEM_WR: begin
                mux1_s    = MUX1_ALUOUT;
                memoria_w = 1'b1;
            end

            ST_BR: begin
                // Compare A and B; take ALUOut (branch target) when the
                // condition for this opcode holds.
                mux4_s       = MUX4_A;
                mux5_s       = MUX5_B;
                ula_selector = ULA_SUB;
                mux13_s      = MUX13_ALUOUT;
                PC_w         = (opcode == OP_BEQ) ? Igual : ~Igual;
            end

            ST_JUMP: begin
                mux13_s = MUX13_JUMP;
                PC_w    = 1'b1;
            end

            default: ;
        endcase
    end

    assign exc       = (state_q == ST_EXC);
    assign exc_cause = exc_cause_q;
    assign state_out = state_q;

endmodule

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit
// Scoreboard bench for control_unit: each test pushes per-cycle steps
// (inputs to drive + expected state and control vector) into a queue, then
// drains it, driving the inputs and comparing the DUT on the falling edge.
// ---------------------------------------------------------------------------
module tb_control_unit;
    import control_pkg::*;

    localparam int MEM_LAT = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       Overflow, Igual;
    logic       PC_w, memoria_w, IR_w, MDR_w, reg_w, a_w, b_w, ALUOut_w;
    logic [2:0] mux1_s, mux2_s, mux3_s, mux4_s, mux5_s, mux13_s, ula_selector;
    logic       exc;
    logic [1:0] exc_cause;
    logic [4:0] state_out;

    control_unit #(.MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .Overflow(Overflow), .Igual(Igual),
        .PC_w(PC_w), .memoria_w(memoria_w), .IR_w(IR_w), .MDR_w(MDR_w),
        .reg_w(reg_w), .a_w(a_w), .b_w(b_w), .ALUOut_w(ALUOut_w),
        .mux1_s(mux1_s), .mux2_s(mux2_s), .mux3_s(mux3_s), .mux4_s(mux4_s),
        .mux5_s(mux5_s), .mux13_s(mux13_s), .ula_selector(ula_selector),
        .exc(exc), .exc_cause(exc_cause), .state_out(state_out)
    );

    always #5 clk = ~clk;

    // All outputs except state_out, packed for one-shot comparison.
    logic [31:0] ctl_obs;
    assign ctl_obs = {PC_w, memoria_w, IR_w, MDR_w, reg_w, a_w, b_w, ALUOut_w,
                      mux1_s, mux2_s, mux3_s, mux4_s, mux5_s, mux13_s,
                      ula_selector, exc, exc_cause};

    function automatic logic [31:0] mk(
        input int pcw, input int memw, input int irw, input int mdrw,
        input int regw, input int aw, input int bw, input int aluw,
        input int m1, input int m2, input int m3, input int m4,
        input int m5, input int m13, input int ula, input int ex, input int cause);
        return {pcw[0], memw[0], irw[0], mdrw[0], regw[0], aw[0], bw[0], aluw[0],
                m1[2:0], m2[2:0], m3[2:0], m4[2:0], m5[2:0], m13[2:0],
                ula[2:0], ex[0], cause[1:0]};
    endfunction

    //                               pc mw ir md rg a  b  ao m1 m2 m3 m4 m5 m13 ula ex ca
    localparam logic [31:0] C_IDLE     = 32'h0;
    localparam logic [31:0] C_FETCH    = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 1, 0, 0);
    localparam logic [31:0] C_DECODE   = mk(0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 2, 0, 1, 0, 0);
    localparam logic [31:0] C_EXR_ADD  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0);
    localparam logic [31:0] C_EXR_SUB  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 2, 0, 0);
    localparam logic [31:0] C_EXR_AND  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 3, 0, 0);
    localparam logic [31:0] C_WBR      = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    localparam logic [31:0] C_EXI      = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0);
    localparam logic [31:0] C_WBI      = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    localparam logic [31:0] C_MRD      = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    localparam logic [31:0] C_MRD_LAST = mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    localparam logic [31:0] C_WBLW     = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    localparam logic [31:0] C_MWR      = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    localparam logic [31:0] C_BR_T     = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2, 0, 0);
    localparam logic [31:0] C_BR_N     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2, 0, 0);
    localparam logic [31:0] C_JUMP     = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0);
    localparam logic [31:0] C_EXC_ILL  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    localparam logic [31:0] C_EXC_OVF  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        ovf;
        logic        ig;
        logic        rst;
        logic [4:0]  st;
        logic [31:0] ctl;
    } step_t;

    step_t sb[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    logic [5:0] cur_op = 6'h00;
    logic [5:0] cur_fn = 6'h00;
    logic       cur_ovf = 1'b0;
    logic       cur_ig = 1'b0;

    // ---------------- stimulus / expectation builders ----------------
    task automatic set_in(input logic [5:0] op, input logic [5:0] fn,
                          input logic ovf, input logic ig);
        cur_op = op; cur_fn = fn; cur_ovf = ovf; cur_ig = ig;
    endtask

    task automatic push(input logic [4:0] st, input logic [31:0] ctl);
        step_t s;
        s.op = cur_op; s.fn = cur_fn; s.ovf = cur_ovf; s.ig = cur_ig;
        s.rst = 1'b1; s.st = st; s.ctl = ctl;
        sb.push_back(s);
    endtask

    task automatic push_rst(input int n);
        step_t s;
        for (int i = 0; i < n; i++) begin
            s.op = cur_op; s.fn = cur_fn; s.ovf = cur_ovf; s.ig = cur_ig;
            s.rst = 1'b0; s.st = ST_RESET; s.ctl = C_IDLE;
            sb.push_back(s);
        end
    endtask

    task automatic push_fetch_decode();
        for (int i = 0; i < MEM_LAT; i++) push(ST_FETCH, C_IDLE);
        push(ST_FETCH, C_FETCH);
        push(ST_DECODE, C_DECODE);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        step_t e;
        int    k = 0;
        push_rst(3);
        set_in(6'h02, 6'h00, 1'b0, 1'b0);          // j after release
        push_fetch_decode();
        push(ST_JUMP, C_JUMP);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            opcode = e.op; funct = e.fn; Overflow = e.ovf; Igual = e.ig; reset = e.rst;
            @(negedge clk);
            n_cmp++;
            if (state_out !== e.st || ctl_obs !== e.ctl) begin
                n_bad++;
                $display("FAIL reset step %0d: state_out=%0d ctl=%08h, expected state_out=%0d ctl=%08h",
                         k, state_out, ctl_obs, e.st, e.ctl);
            end
            k++;
        end
        $display("test_reset: %0d steps", k);
    endtask

    task automatic test_rtype();
        step_t e;
        int    k = 0;
        set_in(6'h00, 6'h20, 1'b0, 1'b0);          // add
        push_fetch_decode(); push(ST_EXEC_R, C_EXR_ADD); push(ST_WB_R, C_WBR);
        set_in(6'h00, 6'h22, 1'b0, 1'b0);          // sub
        push_fetch_decode(); push(ST_EXEC_R, C_EXR_SUB); push(ST_WB_R, C_WBR);
        set_in(6'h00, 6'h24, 1'b1, 1'b0);          // and: overflow flag ignored
        push_fetch_decode(); push(ST_EXEC_R, C_EXR_AND); push(ST_WB_R, C_WBR);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            opcode = e.op; funct = e.fn; Overflow = e.ovf; Igual = e.ig; reset = e.rst;
            @(negedge clk);
            n_cmp++;
            if (state_out !== e.st || ctl_obs !== e.ctl) begin
                n_bad++;
                $display("FAIL rtype step %0d: state_out=%0d ctl=%08h, expected state_out=%0d ctl=%08h",
                         k, state_out, ctl_obs, e.st, e.ctl);
            end
            k++;
        end
        $display("test_rtype: %0d steps", k);
    endtask

    task automatic test_lw();
        step_t e;
        int    k = 0;
        for (int v = 0; v < 2; v++) begin
            // second pass: address overflow must not trap
            set_in(6'h23, 6'h00, v[0], 1'b0);
            push_fetch_decode();
            push(ST_ADDR, C_EXI);
            for (int i = 0; i < MEM_LAT; i++) push(ST_MEM_RD, C_MRD);
            push(ST_MEM_RD, C_MRD_LAST);
            push(ST_WB_LW, C_WBLW);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            opcode = e.op; funct = e.fn; Overflow = e.ovf; Igual = e.ig; reset = e.rst;
            @(negedge clk);
            n_cmp++;
            if (state_out !== e.st || ctl_obs !== e.ctl) begin
                n_bad++;
                $display("FAIL lw step %0d: state_out=%0d ctl=%08h, expected state_out=%0d ctl=%08h",
                         k, state_out, ctl_obs, e.st, e.ctl);
            end
            k++;
        end
        $display("test_lw: %0d steps", k);
    endtask

    task automatic test_branch();
        step_t e;
        int    k = 0;
        set_in(6'h04, 6'h00, 1'b0, 1'b1); push_fetch_decode(); push(ST_BR, C_BR_T); // beq taken
        set_in(6'h05, 6'h00, 1'b0, 1'b1); push_fetch_decode(); push(ST_BR, C_BR_N); // bne not taken
        set_in(6'h04, 6'h00, 1'b0, 1'b0); push_fetch_decode(); push(ST_BR, C_BR_N); // beq not taken
        set_in(6'h05, 6'h00, 1'b0, 1'b0); push_fetch_decode(); push(ST_BR, C_BR_T); // bne taken
        while (sb.size() > 0) begin
            e = sb.pop_front();
            opcode = e.op; funct = e.fn; Overflow = e.ovf; Igual = e.ig; reset = e.rst;
            @(negedge clk);
            n_cmp++;
            if (state_out !== e.st || ctl_obs !== e.ctl) begin
                n_bad++;
                $display("FAIL branch step %0d: state_out=%0d ctl=%08h, expected state_out=%0d ctl=%08h",
                         k, state_out, ctl_obs, e.st, e.ctl);
            end
            k++;
        end
        $display("test_branch: %0d steps", k);
    endtask

    task automatic test_back_to_back();
        step_t e;
        int    k = 0;
        set_in(6'h08, 6'h00, 1'b0, 1'b0);          // addi
        push_fetch_decode(); push(ST_EXEC_I, C_EXI); push(ST_WB_I, C_WBI);
        set_in(6'h2B, 6'h00, 1'b0, 1'b0);          // sw
        push_fetch_decode(); push(ST_ADDR, C_EXI); push(ST_MEM_WR, C_MWR);
        set_in(6'h02, 6'h00, 1'b0, 1'b0);          // j
        push_fetch_decode(); push(ST_JUMP, C_JUMP);
        set_in(6'h00, 6'h22, 1'b1, 1'b0);          // sub overflow -> trap
        push_fetch_decode(); push(ST_EXEC_R, C_EXR_SUB); push(ST_EXC, C_EXC_OVF);
        push_rst(1);
        set_in(6'h2B, 6'h00, 1'b0, 1'b0);          // sw after recovery
        push_fetch_decode(); push(ST_ADDR, C_EXI); push(ST_MEM_WR, C_MWR);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            opcode = e.op; funct = e.fn; Overflow = e.ovf; Igual = e.ig; reset = e.rst;
            @(negedge clk);
            n_cmp++;
            if (state_out !== e.st || ctl_obs !== e.ctl) begin
                n_bad++;
                $display("FAIL b2b step %0d: state_out=%0d ctl=%08h, expected state_out=%0d ctl=%08h",
                         k, state_out, ctl_obs, e.st, e.ctl);
            end
            k++;
        end
        $display("test_back_to_back: %0d steps", k);
    endtask

    task automatic test_addi_ovf();
        step_t e;
        int    k = 0;
        set_in(6'h08, 6'h00, 1'b1, 1'b0);
        push_fetch_decode(); push(ST_EXEC_I, C_EXI);
        push(ST_EXC, C_EXC_OVF); push(ST_EXC, C_EXC_OVF);
        set_in(6'h02, 6'h00, 1'b0, 1'b1);          // new inputs must not wake it
        for (int i = 0; i < 3; i++) push(ST_EXC, C_EXC_OVF);
        push_rst(1);
        set_in(6'h02, 6'h00, 1'b0, 1'b0);
        push_fetch_decode(); push(ST_JUMP, C_JUMP);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            opcode = e.op; funct = e.fn; Overflow = e.ovf; Igual = e.ig; reset = e.rst;
            @(negedge clk);
            n_cmp++;
            if (state_out !== e.st || ctl_obs !== e.ctl) begin
                n_bad++;
                $display("FAIL addi_ovf step %0d: state_out=%0d ctl=%08h, expected state_out=%0d ctl=%08h",
                         k, state_out, ctl_obs, e.st, e.ctl);
            end
            k++;
        end
        $display("test_addi_ovf: %0d steps", k);
    endtask

    task automatic test_illegal();
        step_t e;
        int    k = 0;
        set_in(6'h00, 6'h21, 1'b0, 1'b0);          // R-type, unsupported funct
        push_fetch_decode(); push(ST_EXC, C_EXC_ILL); push(ST_EXC, C_EXC_ILL);
        push_rst(1);
        set_in(6'h3F, 6'h00, 1'b0, 1'b0);          // illegal opcode
        push_fetch_decode(); push(ST_EXC, C_EXC_ILL); push(ST_EXC, C_EXC_ILL);
        push_rst(1);
        set_in(6'h23, 6'h00, 1'b0, 1'b0);          // lw aborted mid-MEM_RD
        push_fetch_decode(); push(ST_ADDR, C_EXI); push(ST_MEM_RD, C_MRD);
        push_rst(2);
        set_in(6'h02, 6'h00, 1'b0, 1'b0);
        push_fetch_decode(); push(ST_JUMP, C_JUMP);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            opcode = e.op; funct = e.fn; Overflow = e.ovf; Igual = e.ig; reset = e.rst;
            @(negedge clk);
            n_cmp++;
            if (state_out !== e.st || ctl_obs !== e.ctl) begin
                n_bad++;
                $display("FAIL illegal step %0d: state_out=%0d ctl=%08h, expected state_out=%0d ctl=%08h",
                         k, state_out, ctl_obs, e.st, e.ctl);
            end
            k++;
        end
        $display("test_illegal: %0d steps", k);
    endtask

    initial begin
        reset    = 1'b1;
        opcode   = 6'h00;
        funct    = 6'h00;
        Overflow = 1'b0;
        Igual    = 1'b0;
        #1;
        test_reset();
        test_rtype();
        test_lw();
        test_branch();
        test_back_to_back();
        test_addi_ovf();
        test_illegal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
